uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser_if.sv | 41 ++++
 rtl/uart_frame_parser.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
//   Bundles the byte-stream input, the frame hand-off to the consumer and the
//   payload read port of uart_frame_parser.
//   slave  : the parser side (consumes rx bytes / ack / read address,
//            produces frame status, payload data, error and drop pulses).
//   master : the environment side (UART receiver plus frame consumer).
//   Signals:
//     rx_data_i[7:0], rx_done_i   received byte and its one-cycle strobe
//     frame_ack_i                 consumer releases the held frame
//     rd_addr_i[3:0]              payload read address
//     frame_valid_o               a checked frame is held
//     frame_cmd_o[7:0]            command byte of the held frame
//     frame_len_o[4:0]            payload length of the held frame
//     rd_data_o[7:0]              payload byte, one cycle after rd_addr_i
//     frame_err_o, err_code_o[1:0] one-cycle error pulse and its code
//     drop_o                      one-cycle pulse, byte discarded while held
interface uart_frame_parser_if;
  logic [7:0] rx_data_i;
  logic       rx_done_i;
  logic       frame_ack_i;
  logic [3:0] rd_addr_i;
  logic       frame_valid_o;
  logic [7:0] frame_cmd_o;
  logic [4:0] frame_len_o;
  logic [7:0] rd_data_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic       drop_o;

  modport master (
    output rx_data_i, rx_done_i, frame_ack_i, rd_addr_i,
    input  frame_valid_o, frame_cmd_o, frame_len_o, rd_data_o,
    input  frame_err_o, err_code_o, drop_o
  );

  modport slave (
    input  rx_data_i, rx_done_i, frame_ack_i, rd_addr_i,
    output frame_valid_o, frame_cmd_o, frame_len_o, rd_data_o,
    output frame_err_o, err_code_o, drop_o
  );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses a byte stream of frames  AA | CMD | LEN | LEN payload bytes | CSUM
//   where CSUM is the modulo-256 sum of CMD, LEN and the payload. A frame that
//   checks out is held (frame_valid_o) with its command, length and payload
//   buffer stable until the consumer acknowledges it. Bytes arriving while a
//   frame is held are discarded and flagged on drop_o.
//   Error codes on frame_err_o / err_code_o:
//     2'b01 checksum mismatch, 2'b10 length above MAX_LEN, 2'b11 inter-byte timeout
//   Ports:
//     clk_i  system clock
//     rst_i  synchronous active-high reset
//     bus    uart_frame_parser_if.slave (byte input, frame output, read port)
//   Parameters:
//     MAX_LEN      maximum payload length (1..16)
//     TIMEOUT_CYC  maximum inter-byte gap in clocks (timeout build only)
//   Build option:
//     UART_FRAME_TIMEOUT_EN  when defined, an in-frame gap of TIMEOUT_CYC clocks
//                            without a byte aborts the frame with code 2'b11.
//                            When undefined, a stalled frame waits indefinitely.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 104160
) (
  input logic                clk_i,
  input logic                rst_i,
  uart_frame_parser_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [7:0] HEADER    = 8'hAA;
  localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    csum_add = acc + data;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] cmd_r, cmd_s;
  logic [4:0] len_r, len_s;
  logic [3:0] idx_r, idx_s;
  logic [7:0] csum_r, csum_s;
  logic       valid_r;
  logic       err_r, err_s;
  logic [1:0] code_r, code_s;
  logic       drop_r, drop_s;
  logic       wr_en_s;
  logic [7:0] rd_data_r;
  logic       active_s;
  logic       to_hit_s;

  logic [7:0] payload_mem [0:15];

  // States in which a frame is partially received and may time out.
  always_comb begin
    active_s = 1'b0;
    case (state_r)
      ST_CMD, ST_LEN, ST_DATA, ST_CSUM: active_s = 1'b1;
      default:                          active_s = 1'b0;
    endcase
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_r;

  // Timeout fires on the cycle the gap counter reaches its last value with no byte.
  always_comb begin
    if (active_s && !bus.rx_done_i && (to_cnt_r == TO_LAST)) begin
      to_hit_s = 1'b1;
    end else begin
      to_hit_s = 1'b0;
    end
  end

  // Inter-byte gap counter: restarts on every byte and outside a partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_r <= '0;
    end else if (bus.rx_done_i || !active_s || to_hit_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  assign to_hit_s = 1'b0;
`endif

  // Next-state and datapath decisions; one byte is consumed per rx_done_i.
  always_comb begin
    state_s = state_r;
    cmd_s   = cmd_r;
    len_s   = len_r;
    idx_s   = idx_r;
    csum_s  = csum_r;
    err_s   = 1'b0;
    code_s  = ERR_NONE;
    drop_s  = 1'b0;
    wr_en_s = 1'b0;

    if (to_hit_s) begin
      err_s   = 1'b1;
      code_s  = ERR_TIMEOUT;
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_done_i && (bus.rx_data_i == HEADER)) begin
            csum_s  = 8'h00;
            state_s = ST_CMD;
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_CMD: begin
          if (bus.rx_done_i) begin
            cmd_s   = bus.rx_data_i;
            csum_s  = csum_add(csum_r, bus.rx_data_i);
            state_s = ST_LEN;
          end else begin
            state_s = ST_CMD;
          end
        end

        ST_LEN: begin
          if (bus.rx_done_i) begin
            csum_s = csum_add(csum_r, bus.rx_data_i);
            idx_s  = 4'd0;
            if (bus.rx_data_i == 8'h00) begin
              len_s   = 5'd0;
              state_s = ST_CSUM;
            end else if (bus.rx_data_i <= {3'b000, MAX_LEN_L}) begin
              len_s   = bus.rx_data_i[4:0];
              state_s = ST_DATA;
            end else begin
              err_s   = 1'b1;
              code_s  = ERR_LEN;
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_LEN;
          end
        end

        ST_DATA: begin
          if (bus.rx_done_i) begin
            wr_en_s = 1'b1;
            csum_s  = csum_add(csum_r, bus.rx_data_i);
            idx_s   = idx_r + 4'd1;
            // idx_r is the slot being written now; the last slot is len-1.
            if ({1'b0, idx_r} == (len_r - 5'd1)) begin
              state_s = ST_CSUM;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            state_s = ST_DATA;
          end
        end

        ST_CSUM: begin
          if (bus.rx_done_i) begin
            if (bus.rx_data_i == csum_r) begin
              state_s = ST_DONE;
            end else begin
              err_s   = 1'b1;
              code_s  = ERR_CSUM;
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_CSUM;
          end
        end

        ST_DONE: begin
          // A byte during the hold is always dropped, even alongside the ack.
          drop_s = bus.rx_done_i;
          if (bus.frame_ack_i) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end

        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, frame fields, checksum and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cmd_r     <= 8'h00;
      len_r     <= 5'd0;
      idx_r     <= 4'd0;
      csum_r    <= 8'h00;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      code_r    <= ERR_NONE;
      drop_r    <= 1'b0;
      rd_data_r <= 8'h00;
    end else begin
      state_r   <= state_s;
      cmd_r     <= cmd_s;
      len_r     <= len_s;
      idx_r     <= idx_s;
      csum_r    <= csum_s;
      valid_r   <= (state_s == ST_DONE);
      err_r     <= err_s;
      code_r    <= code_s;
      drop_r    <= drop_s;
      rd_data_r <= payload_mem[bus.rd_addr_i];
    end
  end

  // Payload buffer write port; contents are not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      payload_mem[idx_r] <= bus.rx_data_i;
    end
  end

  assign bus.frame_valid_o = valid_r;
  assign bus.frame_cmd_o   = cmd_r;
  assign bus.frame_len_o   = len_r;
  assign bus.rd_data_o     = rd_data_r;
  assign bus.frame_err_o   = err_r;
  assign bus.err_code_o    = code_r;
  assign bus.drop_o        = drop_r;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//   Directed bench for uart_frame_parser. A byte-level frame model (queue of
//   bytes since the header, checked when the frame length is reached) predicts
//   the outputs each cycle; literal expectations pin the headline scenarios.
module tb_uart_frame_parser;
  localparam int MAXL = 16;
  localparam int TO   = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_parser_if ifc();

  uart_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_live = 1'b0;
  bit          m_collect = 1'b0;
  bit          m_hold = 1'b0;
  int unsigned m_q[$];
  int unsigned m_pay[16];
  int unsigned m_cmd = 0;
  int unsigned m_len = 0;
  int          m_idle = 0;
  bit          e_valid = 1'b0, e_err = 1'b0, e_drop = 1'b0, e_rd_ok = 1'b0;
  int unsigned e_code = 0, e_rd = 0;

  task automatic model_step();
    int unsigned b;
    int unsigned n;
    int unsigned s;
    e_err  = 1'b0;
    e_code = 0;
    e_drop = 1'b0;
    if (rst) begin
      m_live = 1'b1; m_collect = 1'b0; m_hold = 1'b0; m_q = {};
      m_cmd = 0; m_len = 0; m_idle = 0;
      e_valid = 1'b0; e_rd_ok = 1'b1; e_rd = 0;
      return;
    end
    // Read port sees the held buffer, which is unchanged by this edge.
    e_rd_ok = m_hold && (ifc.rd_addr_i < m_len);
    e_rd    = e_rd_ok ? m_pay[ifc.rd_addr_i] : 0;
    b = ifc.rx_data_i;
    if (m_hold) begin
      if (ifc.rx_done_i) e_drop = 1'b1;
      if (ifc.frame_ack_i) m_hold = 1'b0;
    end else if (m_collect) begin
      if (ifc.rx_done_i) begin
        m_idle = 0;
        m_q.push_back(b);
        n = m_q.size();
        if (n == 2 && m_q[1] > MAXL) begin
          e_err = 1'b1; e_code = 2; m_collect = 1'b0;
        end else if (n >= 3 && n == m_q[1] + 3) begin
          s = 0;
          for (int i = 0; i < n - 1; i++) s += m_q[i];
          if ((s % 256) == m_q[n-1]) begin
            m_hold = 1'b1; m_cmd = m_q[0]; m_len = m_q[1];
            for (int i = 0; i < m_len; i++) m_pay[i] = m_q[2+i];
          end else begin
            e_err = 1'b1; e_code = 1;
          end
          m_collect = 1'b0;
        end
      end else begin
`ifdef UART_FRAME_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          e_err = 1'b1; e_code = 3; m_collect = 1'b0;
        end
`endif
      end
    end else if (ifc.rx_done_i && b == 8'hAA) begin
      m_collect = 1'b1; m_q = {}; m_idle = 0;
    end
    e_valid = m_hold;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_valid", ifc.frame_valid_o, e_valid);
      chk("cyc_err", ifc.frame_err_o, e_err);
      chk("cyc_drop", ifc.drop_o, e_drop);
      if (e_err) chk("cyc_code", ifc.err_code_o, e_code);
      if (e_valid) begin
        chk("cyc_cmd", ifc.frame_cmd_o, m_cmd);
        chk("cyc_len", ifc.frame_len_o, m_len);
      end
      if (e_rd_ok) chk("cyc_rd", ifc.rd_data_o, e_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ifc.rx_data_i = b;
    ifc.rx_done_i = 1'b1;
    @(negedge clk);
    ifc.rx_done_i = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    ifc.frame_ack_i = 1'b1;
    @(negedge clk);
    ifc.frame_ack_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, ifc.frame_valid_o, 32'd0);
    chk({tag, "_err"}, ifc.frame_err_o, 32'd0);
    chk({tag, "_code"}, ifc.err_code_o, 32'd0);
    chk({tag, "_drop"}, ifc.drop_o, 32'd0);
    chk({tag, "_cmd"}, ifc.frame_cmd_o, 32'd0);
    chk({tag, "_len"}, ifc.frame_len_o, 32'd0);
    chk({tag, "_rd"}, ifc.rd_data_o, 32'd0);
  endtask

  initial begin
    ifc.rx_data_i   = 8'h00;
    ifc.rx_done_i   = 1'b0;
    ifc.frame_ack_i = 1'b0;
    ifc.rd_addr_i   = 4'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;

    // Good frame AA 01 02 10 20 33
    send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    chk("good_valid", ifc.frame_valid_o, 32'd1);
    chk("good_cmd", ifc.frame_cmd_o, 32'h01);
    chk("good_len", ifc.frame_len_o, 32'd2);
    @(negedge clk); ifc.rd_addr_i = 4'd0;
    @(negedge clk); chk("good_rd0", ifc.rd_data_o, 32'h10); ifc.rd_addr_i = 4'd1;
    @(negedge clk); chk("good_rd1", ifc.rd_data_o, 32'h20);
    repeat (5) @(negedge clk);
    chk("good_hold", ifc.frame_valid_o, 32'd1);
    ack();
    chk("good_ack", ifc.frame_valid_o, 32'd0);

    // Bad checksum, then recovery with AA 03 01 7F 83
    send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h34);
    chk("bad_err", ifc.frame_err_o, 32'd1);
    chk("bad_code", ifc.err_code_o, 32'd1);
    chk("bad_valid", ifc.frame_valid_o, 32'd0);
    @(negedge clk);
    chk("bad_err_one", ifc.frame_err_o, 32'd0);
    send(8'hAA); send(8'h03); send(8'h01); send(8'h7F); send(8'h83);
    chk("rec_valid", ifc.frame_valid_o, 32'd1);
    chk("rec_cmd", ifc.frame_cmd_o, 32'h03);
    ifc.rd_addr_i = 4'd0;
    @(negedge clk); chk("rec_rd0", ifc.rd_data_o, 32'h7F);
    ack();

    // Over-length, then zero-length frame
    send(8'hAA); send(8'h05); send(8'h11);
    chk("olen_err", ifc.frame_err_o, 32'd1);
    chk("olen_code", ifc.err_code_o, 32'd2);
    send(8'hAA); send(8'h07); send(8'h00); send(8'h07);
    chk("zlen_valid", ifc.frame_valid_o, 32'd1);
    chk("zlen_len", ifc.frame_len_o, 32'd0);
    chk("zlen_cmd", ifc.frame_cmd_o, 32'h07);

    // Drop while held, then header coincident with ack
    send(8'h55);
    chk("drop_pulse", ifc.drop_o, 32'd1);
    chk("drop_still_valid", ifc.frame_valid_o, 32'd1);
    @(negedge clk);
    chk("drop_one", ifc.drop_o, 32'd0);
    ifc.rx_data_i = 8'hAA; ifc.rx_done_i = 1'b1; ifc.frame_ack_i = 1'b1;
    @(negedge clk);
    ifc.rx_done_i = 1'b0; ifc.frame_ack_i = 1'b0;
    chk("coinc_drop", ifc.drop_o, 32'd1);
    chk("coinc_valid", ifc.frame_valid_o, 32'd0);
    // Back in IDLE: a would-be frame body without header must be ignored
    send(8'h05); send(8'h00); send(8'h05);
    chk("idle_ignore", ifc.frame_valid_o, 32'd0);

    // Inter-byte gap after AA 01
    send(8'hAA); send(8'h01);
`ifdef UART_FRAME_TIMEOUT_EN
    repeat (99) @(negedge clk);
    chk("to_early", ifc.frame_err_o, 32'd0);
    @(negedge clk);
    chk("to_err", ifc.frame_err_o, 32'd1);
    chk("to_code", ifc.err_code_o, 32'd3);
    send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    chk("to_next_valid", ifc.frame_valid_o, 32'd1);
`else
    repeat (150) @(negedge clk);
    chk("gap_no_err", ifc.frame_err_o, 32'd0);
    send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    chk("gap_valid", ifc.frame_valid_o, 32'd1);
    chk("gap_len", ifc.frame_len_o, 32'd2);
`endif
    ack();

    // Reset mid-frame, then a good frame
    send(8'hAA); send(8'h01); send(8'h02); send(8'h10);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mrst");
    rst = 1'b0;
    send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    chk("post_valid", ifc.frame_valid_o, 32'd1);
    chk("post_cmd", ifc.frame_cmd_o, 32'h01);
    ifc.rd_addr_i = 4'd1;
    @(negedge clk); chk("post_rd1", ifc.rd_data_o, 32'h20);
    ack();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
